ex_stage: RTL and testbench

EX_STAGE -- requirements
Module: ex_stage

---
 rtl/ex_pkg.sv | 59 +++++
 rtl/ex_mem_if.sv | 22 ++
 rtl/alu32.sv | 26 ++
 rtl/ex_stage.sv | 86 ++++++++
 tb/tb_ex_stage.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/ex_pkg.sv
// EX stage shared types: ALU op codes, select encodings, funct
// constants, control-bit positions and the EX/MEM bundle.
package ex_pkg;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;
    localparam logic [1:0] ALUOP_ADD2  = 2'b11;

    typedef enum logic [2:0] {
        ALU_AND = 3'b000,
        ALU_OR  = 3'b001,
        ALU_ADD = 3'b010,
        ALU_SUB = 3'b110,
        ALU_SLT = 3'b111
    } alu_sel_e;

    localparam logic [5:0] FUNCT_ADD = 6'h20;
    localparam logic [5:0] FUNCT_SUB = 6'h22;
    localparam logic [5:0] FUNCT_AND = 6'h24;
    localparam logic [5:0] FUNCT_OR  = 6'h25;
    localparam logic [5:0] FUNCT_SLT = 6'h2A;

    localparam int WB_REGWRITE = 1;
    localparam int WB_MEMTOREG = 0;
    localparam int M_BRANCH    = 2;
    localparam int M_MEMREAD   = 1;
    localparam int M_MEMWRITE  = 0;
    localparam int EX_REGDST   = 3;
    localparam int EX_ALUOP_HI = 2;
    localparam int EX_ALUOP_LO = 1;
    localparam int EX_ALUSRC   = 0;

    typedef struct packed {
        logic [1:0]  wb_ctl;
        logic [2:0]  m_ctl;
        logic [31:0] add_result;
        logic        zero;
        logic [31:0] alu_result;
        logic [31:0] rdata2;
        logic [4:0]  dest_reg;
    } exm_t;

    // Unlisted funct codes fall back to add.
    function automatic alu_sel_e funct_sel(input logic [5:0] f);
        alu_sel_e s;
        s = ALU_ADD;
        unique case (1'b1)
            (f == FUNCT_ADD): s = ALU_ADD;
            (f == FUNCT_SUB): s = ALU_SUB;
            (f == FUNCT_AND): s = ALU_AND;
            (f == FUNCT_OR):  s = ALU_OR;
            (f == FUNCT_SLT): s = ALU_SLT;
            default:          s = ALU_ADD;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/ex_mem_if.sv
// EX/MEM pipeline register bundle as seen by the MEM stage.
interface ex_mem_if;

    logic [1:0]  exm_wb_ctl;
    logic [2:0]  exm_m_ctl;
    logic [31:0] exm_add_result;
    logic        exm_zero;
    logic [31:0] exm_alu_result;
    logic [31:0] exm_rdata2;
    logic [4:0]  exm_dest_reg;

    modport master (
        output exm_wb_ctl, exm_m_ctl, exm_add_result, exm_zero,
        output exm_alu_result, exm_rdata2, exm_dest_reg
    );

    modport slave (
        input exm_wb_ctl, exm_m_ctl, exm_add_result, exm_zero,
        input exm_alu_result, exm_rdata2, exm_dest_reg
    );

endinterface

// File: rtl/alu32.sv
// 32-bit combinational ALU: and/or/add/sub/signed slt plus zero flag.
module alu32
    import ex_pkg::*;
(
    input  alu_sel_e    sel,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] result,
    output logic        zero
);

    always_comb begin
        result = '0;
        unique case (sel)
            ALU_AND: result = a & b;
            ALU_OR:  result = a | b;
            ALU_ADD: result = a + b;
            ALU_SUB: result = a - b;
            ALU_SLT: result = {31'b0, $signed(a) < $signed(b)};
            default: result = a + b;
        endcase
    end

    assign zero = (result == 32'h0);

endmodule

// File: rtl/ex_stage.sv
// Execute stage: operand muxing, ALU control, branch target and
// the EX/MEM pipeline register with hold/flush.
module ex_stage
    import ex_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  wb_ctlout,
    input  logic [2:0]  m_ctlout,
    input  logic [3:0]  ex_ctlout,
    input  logic [31:0] npcout,
    input  logic [31:0] rdata1out,
    input  logic [31:0] rdata2out,
    input  logic [31:0] s_extendout,
    input  logic [4:0]  instrout_1511,
    input  logic [4:0]  instrout_2016,
    input  logic        hold,
    input  logic        flush,
    ex_mem_if.master    exm
);

    logic [1:0]  aluop;
    logic        alusrc;
    logic        regdst;
    logic [31:0] op_b;
    alu_sel_e    alu_sel;
    logic [31:0] alu_res;
    logic        alu_zero;
    exm_t        d;
    exm_t        q;

    assign aluop  = ex_ctlout[EX_ALUOP_HI:EX_ALUOP_LO];
    assign alusrc = ex_ctlout[EX_ALUSRC];
    assign regdst = ex_ctlout[EX_REGDST];
    assign op_b   = alusrc ? s_extendout : rdata2out;

    always_comb begin
        alu_sel = ALU_ADD;
        unique case (aluop)
            ALUOP_ADD:   alu_sel = ALU_ADD;
            ALUOP_SUB:   alu_sel = ALU_SUB;
            ALUOP_FUNCT: alu_sel = funct_sel(s_extendout[5:0]);
            ALUOP_ADD2:  alu_sel = ALU_ADD;
        endcase
    end

    alu32 u_alu (
        .sel    (alu_sel),
        .a      (rdata1out),
        .b      (op_b),
        .result (alu_res),
        .zero   (alu_zero)
    );

    always_comb begin
        d.wb_ctl     = wb_ctlout;
        d.m_ctl      = m_ctlout;
        d.add_result = npcout + {s_extendout[29:0], 2'b00};
        d.zero       = alu_zero;
        d.alu_result = alu_res;
        d.rdata2     = rdata2out;
        d.dest_reg   = regdst ? instrout_1511 : instrout_2016;
    end

    // Reset beats flush, flush beats hold.
    always_ff @(posedge clk) begin
        if (!reset) begin
            q <= '0;
        end else if (flush) begin
            q        <= d;
            q.wb_ctl <= '0;
            q.m_ctl  <= '0;
        end else if (!hold) begin
            q <= d;
        end
    end

    assign exm.exm_wb_ctl     = q.wb_ctl;
    assign exm.exm_m_ctl      = q.m_ctl;
    assign exm.exm_add_result = q.add_result;
    assign exm.exm_zero       = q.zero;
    assign exm.exm_alu_result = q.alu_result;
    assign exm.exm_rdata2     = q.rdata2;
    assign exm.exm_dest_reg   = q.dest_reg;

endmodule

// File: tb/tb_ex_stage.sv
// Scoreboard bench for ex_stage: directed vectors, queued
// expectations, monitor compares one edge after each issue.
module tb_ex_stage;
    import ex_pkg::*;

    typedef struct packed {
        logic [1:0]  wb;
        logic [2:0]  m;
        logic [3:0]  ex;
        logic [31:0] npc;
        logic [31:0] r1;
        logic [31:0] r2;
        logic [31:0] se;
        logic [4:0]  rd;
        logic [4:0]  rt;
    } stim_t;

    logic        clk;
    logic        reset;
    logic [1:0]  wb_ctlout;
    logic [2:0]  m_ctlout;
    logic [3:0]  ex_ctlout;
    logic [31:0] npcout;
    logic [31:0] rdata1out;
    logic [31:0] rdata2out;
    logic [31:0] s_extendout;
    logic [4:0]  instrout_1511;
    logic [4:0]  instrout_2016;
    logic        hold;
    logic        flush;

    ex_mem_if exm ();

    ex_stage dut (
        .clk           (clk),
        .reset         (reset),
        .wb_ctlout     (wb_ctlout),
        .m_ctlout      (m_ctlout),
        .ex_ctlout     (ex_ctlout),
        .npcout        (npcout),
        .rdata1out     (rdata1out),
        .rdata2out     (rdata2out),
        .s_extendout   (s_extendout),
        .instrout_1511 (instrout_1511),
        .instrout_2016 (instrout_2016),
        .hold          (hold),
        .flush         (flush),
        .exm           (exm)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    exm_t  exp_q[$];
    string name_q[$];
    int    checks = 0;
    int    passed = 0;

    // Monitor: every edge with a pending expectation is compared.
    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            exm_t  e;
            exm_t  g;
            string n;
            e = exp_q.pop_front();
            n = name_q.pop_front();
            g = '{exm.exm_wb_ctl, exm.exm_m_ctl,
                  exm.exm_add_result, exm.exm_zero,
                  exm.exm_alu_result, exm.exm_rdata2,
                  exm.exm_dest_reg};
            checks++;
            if (g === e) passed++;
            else $display("FAIL %s: got %h expected %h", n, g, e);
        end
    end

    task automatic issue(input string nm, input stim_t s,
                         input logic rst, input logic h,
                         input logic f, input exm_t e);
        @(negedge clk);
        reset         = rst;
        hold          = h;
        flush         = f;
        wb_ctlout     = s.wb;
        m_ctlout      = s.m;
        ex_ctlout     = s.ex;
        npcout        = s.npc;
        rdata1out     = s.r1;
        rdata2out     = s.r2;
        s_extendout   = s.se;
        instrout_1511 = s.rd;
        instrout_2016 = s.rt;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    stim_t v1, v2, v3, v4, v5, v6, v7, v8, v9, v10, v11, v12;
    stim_t vhf, vfl;
    exm_t  e1, e2, e3, e4, e5, e6, e7, e8, e9, e10, e11, e12;
    exm_t  ehf, efl;
    exm_t  ez;

    initial begin
        reset = 1'b0; hold = 1'b0; flush = 1'b0;
        wb_ctlout = '0; m_ctlout = '0; ex_ctlout = '0;
        npcout = '0; rdata1out = '0; rdata2out = '0;
        s_extendout = '0; instrout_1511 = '0; instrout_2016 = '0;
        ez = '0;

        v1  = '{2'b10, 3'b000, 4'b1100, 32'h4, 32'hA000,
                32'h440, 32'h20, 5'd3, 5'd7};
        e1  = '{2'b10, 3'b000, 32'h84, 1'b0, 32'hA440,
                32'h440, 5'd3};
        v2  = '{2'b00, 3'b100, 4'b0010, 32'h002A0A45, 32'h440,
                32'h440, 32'hF, 5'd2, 5'd9};
        e2  = '{2'b00, 3'b100, 32'h002A0A81, 1'b1, 32'h0,
                32'h440, 5'd9};
        v3  = '{2'b10, 3'b000, 4'b1100, 32'h100, 32'hFFFFFFFF,
                32'h1, 32'h2A, 5'd4, 5'd0};
        e3  = '{2'b10, 3'b000, 32'h1A8, 1'b0, 32'h1,
                32'h1, 5'd4};
        v4  = '{2'b11, 3'b010, 4'b0001, 32'h200, 32'h000FC865,
                32'h12345678, 32'hAA, 5'd31, 5'd8};
        e4  = '{2'b11, 3'b010, 32'h4A8, 1'b0, 32'h000FC90F,
                32'h12345678, 5'd8};
        v5  = '{2'b10, 3'b000, 4'b1100, 32'h0, 32'h10,
                32'h3, 32'h22, 5'd1, 5'd2};
        e5  = '{2'b10, 3'b000, 32'h88, 1'b0, 32'hD,
                32'h3, 5'd1};
        v6  = '{2'b10, 3'b000, 4'b1100, 32'h0, 32'hF0F0F0F0,
                32'h0FF00FF0, 32'h24, 5'd5, 5'd6};
        e6  = '{2'b10, 3'b000, 32'h90, 1'b0, 32'h00F000F0,
                32'h0FF00FF0, 5'd5};
        v7  = '{2'b10, 3'b000, 4'b1100, 32'h0, 32'hF0000000,
                32'hF, 32'h25, 5'd6, 5'd7};
        e7  = '{2'b10, 3'b000, 32'h94, 1'b0, 32'hF000000F,
                32'hF, 5'd6};
        v8  = '{2'b10, 3'b000, 4'b1100, 32'h0, 32'h1,
                32'h2, 32'h3F, 5'd7, 5'd8};
        e8  = '{2'b10, 3'b000, 32'hFC, 1'b0, 32'h3,
                32'h2, 5'd7};
        v9  = '{2'b01, 3'b001, 4'b0110, 32'h40, 32'h5,
                32'h7, 32'h0, 5'd1, 5'd10};
        e9  = '{2'b01, 3'b001, 32'h40, 1'b0, 32'hC,
                32'h7, 5'd10};
        v10 = '{2'b10, 3'b000, 4'b1100, 32'h20, 32'h1,
                32'hFFFFFFFF, 32'h2A, 5'd11, 5'd12};
        e10 = '{2'b10, 3'b000, 32'hC8, 1'b1, 32'h0,
                32'hFFFFFFFF, 5'd11};
        v11 = '{2'b00, 3'b001, 4'b0000, 32'hFFFFFFFC, 32'hFFFFFFFF,
                32'h1, 32'h40000001, 5'd13, 5'd14};
        e11 = '{2'b00, 3'b001, 32'h0, 1'b1, 32'h0,
                32'h1, 5'd14};
        v12 = '{2'b11, 3'b010, 4'b0001, 32'h100, 32'h10,
                32'h55, 32'hFFFFFFFF, 5'd15, 5'd16};
        e12 = '{2'b11, 3'b010, 32'hFC, 1'b0, 32'hF,
                32'h55, 5'd16};
        vhf = '{2'b10, 3'b101, 4'b1100, 32'h4, 32'hA000,
                32'h440, 32'h20, 5'd3, 5'd7};
        ehf = '{2'b00, 3'b000, 32'h84, 1'b0, 32'hA440,
                32'h440, 5'd3};
        vfl = '{2'b11, 3'b010, 4'b1100, 32'h0, 32'h10,
                32'h3, 32'h22, 5'd1, 5'd2};
        efl = '{2'b00, 3'b000, 32'h88, 1'b0, 32'hD,
                32'h3, 5'd1};

        issue("reset0", v1, 1'b0, 1'b0, 1'b0, ez);
        issue("reset1", v2, 1'b0, 1'b0, 1'b0, ez);
        issue("radd", v1, 1'b1, 1'b0, 1'b0, e1);
        issue("beq_sub", v2, 1'b1, 1'b0, 1'b0, e2);
        issue("slt_neg", v3, 1'b1, 1'b0, 1'b0, e3);
        issue("imm_add", v4, 1'b1, 1'b0, 1'b0, e4);
        issue("rsub", v5, 1'b1, 1'b0, 1'b0, e5);
        issue("rand", v6, 1'b1, 1'b0, 1'b0, e6);
        issue("ror", v7, 1'b1, 1'b0, 1'b0, e7);
        issue("funct_dflt", v8, 1'b1, 1'b0, 1'b0, e8);
        issue("aluop11", v9, 1'b1, 1'b0, 1'b0, e9);
        issue("slt_false", v10, 1'b1, 1'b0, 1'b0, e10);
        issue("wrap", v11, 1'b1, 1'b0, 1'b0, e11);
        issue("neg_off", v12, 1'b1, 1'b0, 1'b0, e12);
        issue("hold1", v1, 1'b1, 1'b1, 1'b0, e12);
        issue("hold2", v3, 1'b1, 1'b1, 1'b0, e12);
        issue("hold_flush", vhf, 1'b1, 1'b1, 1'b1, ehf);
        issue("flush", vfl, 1'b1, 1'b0, 1'b1, efl);
        issue("refill", v1, 1'b1, 1'b0, 1'b0, e1);
        issue("mid_reset", v2, 1'b0, 1'b1, 1'b0, ez);
        issue("post_reset", v3, 1'b1, 1'b0, 1'b0, e3);

        @(negedge clk);
        @(negedge clk);
        checks++;
        if (exp_q.size() == 0) passed++;
        else $display("FAIL drain: got %0d pending expected 0",
                      exp_q.size());

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
